dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1-style slice through an N-sample multiply-accumulate: P = ±Σ(A·B).
- Accepts operand samples over a valid/ready handshake and issues the operand-register clock enable.
- Drives the slice's opmode and P-register enable, aligned to the slice's operand→post-adder latency.
- Pulses done in the cycle P holds the final sum. Sits between the sample source and the slice wrapper.

Parameters:
- LEN_W, 8: width of the sample-count input.
- OPM_LAT, 2: cycles from sample acceptance to the cycle its opmode/ce_p must be presented to the slice. Legal range ≥1.
- SUB, 0: 1 sets opmode[7], post-adder subtract, on every issued accumulate op.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  LEN_W  number of samples; captured on start.
- in_valid  in  1  sample source presents A/B operands.
- in_ready  out  1  sequencer accepts a sample this cycle.
- ce_ab  out  1  operand-register CE; equals in_valid & in_ready (combinational).
- opmode  out  8  slice opmode, registered.
- ce_p  out  1  P-register CE, registered, aligned with opmode.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse; P holds the result this cycle.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-job):
  - state=IDLE; count=0; token pipeline cleared.
  - opmode=8'h00, ce_p=0, busy=0, done=0, in_ready=0.
  - An in-flight job is abandoned; no done is produced.
- States:
  - IDLE: start=1 → latch len, count=0. Go to RUN if len≠0, else CLEAR.
  - RUN: in_ready=1. Each accept (in_valid=1) pushes token {v=1, first=(count==0)} and increments count. The accept with count==len-1 → DRAIN.
  - CLEAR: one cycle. Pushes token {v=1, clr=1}, then → DRAIN.
  - DRAIN: in_ready=0. Wait until the token pipeline is empty and the last issued op has been clocked into P, then → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- busy=1 in RUN, CLEAR, DRAIN and DONE; busy=0 in IDLE.
- start is ignored outside IDLE.
- Token pipeline: OPM_LAT stages. A token pushed at cycle t drives outputs at cycle t+OPM_LAT. Cycles with no accept push a bubble (v=0).
- Opmode decode of the output-stage token (X=bits[1:0], Z=bits[3:2]):
  - first: 8'h01 | SUB<<7 — X=M, Z=0.
  - non-first: 8'h09 | SUB<<7 — X=M, Z=P.
  - clr: 8'h00, ce_p=1 — P←0.
  - bubble: opmode=8'h00, ce_p=0 — P holds.
  - opmode[6:4] is always 0; no pre-adder, carry-in 0.
- ce_p=1 exactly when the output-stage token has v=1.
- done timing: asserted the cycle after the last ce_p=1. Last sample accepted at t_L → done at t_L+OPM_LAT+1; busy falls the following cycle.
- len=0: one clear op, ce_p at start+1+OPM_LAT, done the cycle after.
- len=max (2^LEN_W−1): count must not wrap before the RUN→DRAIN transition.
- Back-to-back jobs: start in the first IDLE cycle after done is accepted.
- P is never enabled while IDLE, so the result persists until the next job's first op.

Test Plan:
- OPM_LAT=2, SUB=0, start@0, len=3, in_valid held 1 → accepts at cycles 1,2,3; opmode 01,09,09 with ce_p=1 at cycles 3,4,5; done at cycle 6; busy=0 at cycle 7. With A·B = 2,3,4 per sample, P=9 at done.
- Same job, in_valid=0 at cycle 2 → accepts at 1,3,4; ce_p=1 at 3,5,6, and ce_p=0 with opmode=00 at cycle 4; done at cycle 7; P still 9.
- start with len=0 → in_ready never 1; single op opmode=00, ce_p=1 at cycle 3; done at cycle 4; P=0.
- SUB=1, len=2, products 5 and 3 → opmode 81 then 89; P=−8 at done.
- rst=1 at cycle 3 of a len=4 job → all outputs at reset values at cycle 4; no done; a new start at cycle 5 runs normally.
- start asserted while busy → ignored; len change mid-job has no effect; after done, P holds its value for 10 idle cycles with ce_p=0.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1-style slice through P = +/-sum(A*B); opmode/ce_p trail each accept by OPM_LAT cycles.
// Backpressure: in_ready is high only while collecting samples; the source stalls freely via in_valid.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int OPM_LAT = 2,
  parameter bit SUB     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic [7:0]       opmode,
  output logic             ce_p,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CLEAR, S_DRAIN, S_DONE} state_t;

  localparam logic [OPM_LAT-1:0] PEND_MASK = OPM_LAT'((64'd1 << (OPM_LAT - 1)) - 64'd1);
  localparam logic [7:0]         SUB_BIT   = SUB ? 8'h80 : 8'h00;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   count_q, count_d;
  // Token pipeline as bit-slices; index OPM_LAT-1 is the stage presented to the slice.
  logic [OPM_LAT-1:0] tv_q, tf_q, tc_q;
  logic               push_v, push_f, push_c;
  logic               accept, pending;

  assign in_ready = (state_q == S_RUN);
  assign accept   = in_valid & in_ready;
  assign ce_ab    = accept;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign pending  = |(tv_q & PEND_MASK);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    push_v  = 1'b0;
    push_f  = 1'b0;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          count_d = '0;
          state_d = (len == '0) ? S_CLEAR : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          push_v  = 1'b1;
          push_f  = (count_q == '0);
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_CLEAR: begin
        push_v  = 1'b1;
        push_c  = 1'b1;
        state_d = S_DRAIN;
      end
      // The output-stage op is clocked into P on the same edge that leaves DRAIN.
      S_DRAIN: if (!pending) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      tv_q    <= '0;
      tf_q    <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      tv_q    <= OPM_LAT'({tv_q, push_v});
      tf_q    <= OPM_LAT'({tf_q, push_f});
      tc_q    <= OPM_LAT'({tc_q, push_c});
    end
  end

  always_comb begin
    opmode = 8'h00;
    ce_p   = tv_q[OPM_LAT-1];
    if (tv_q[OPM_LAT-1] && !tc_q[OPM_LAT-1])
      opmode = (tf_q[OPM_LAT-1] ? 8'h01 : 8'h09) | SUB_BIT;
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: SUB=0 and SUB=1 instances share stimulus; a slice model
// accumulates the products and a queue scoreboard checks every issued op.
module tb_dsp_mac_sequencer;

  localparam int LEN_W   = 8;
  localparam int OPM_LAT = 2;

  typedef struct {
    int         cyc;
    logic [7:0] op;
    int         prod;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [LEN_W-1:0] len = '0;

  logic       rdy0, ceab0, cep0, busy0, done0;
  logic       rdy1, ceab1, cep1, busy1, done1;
  logic [7:0] op0, op1;

  logic       sel = 1'b0;
  logic       m_rdy, m_ceab, m_cep, m_busy, m_done;
  logic [7:0] m_op;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   acc_n = 0;
  int   first_acc_cyc = -1;
  int   p_model = 0;
  exp_t exp_q[$];
  int   src_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .OPM_LAT(OPM_LAT), .SUB(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy0), .ce_ab(ceab0), .opmode(op0), .ce_p(cep0), .busy(busy0), .done(done0));

  dsp_mac_sequencer #(.LEN_W(LEN_W), .OPM_LAT(OPM_LAT), .SUB(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy1), .ce_ab(ceab1), .opmode(op1), .ce_p(cep1), .busy(busy1), .done(done1));

  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_ceab = sel ? ceab1 : ceab0;
  assign m_cep  = sel ? cep1  : cep0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_op   = sel ? op1   : op0;

  // Scoreboard monitor plus slice model, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid || m_rdy) begin
        vectors++;
        if (m_ceab !== (in_valid & m_rdy)) begin
          miscompares++;
          $display("FAIL ce_ab cyc=%0d: got %b want %b", cyc, m_ceab, in_valid & m_rdy);
        end
      end
      if (in_valid === 1'b1 && m_rdy === 1'b1) begin
        mon_e.cyc  = cyc + OPM_LAT;
        mon_e.op   = ((acc_n == 0) ? 8'h01 : 8'h09) | (sel ? 8'h80 : 8'h00);
        mon_e.prod = (src_q.size() > 0) ? src_q.pop_front() : 0;
        exp_q.push_back(mon_e);
        if (acc_n == 0) first_acc_cyc = cyc;
        acc_n++;
      end
      if (m_cep === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_op cyc=%0d: got opmode %h, want no op", cyc, m_op);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc !== mon_e.cyc || m_op !== mon_e.op) begin
            miscompares++;
            $display("FAIL op_issue: got cyc=%0d opmode=%h want cyc=%0d opmode=%h",
                     cyc, m_op, mon_e.cyc, mon_e.op);
          end
          p_model = (m_op[7] ? ((m_op[3:2] == 2'b10) ? p_model : 0) - ((m_op[1:0] == 2'b01) ? mon_e.prod : 0)
                             : ((m_op[3:2] == 2'b10) ? p_model : 0) + ((m_op[1:0] == 2'b01) ? mon_e.prod : 0));
        end
      end else if (m_op !== 8'h00) begin
        vectors++;
        miscompares++;
        $display("FAIL bubble_opmode cyc=%0d: got %h want 00", cyc, m_op);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (m_done === 1'b1) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) step();
    vectors++;
    if (m_op !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_opmode: got %h want 00", m_op);
    end
    vectors++;
    if ({m_cep, m_busy, m_done, m_rdy, m_ceab} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {m_cep, m_busy, m_done, m_rdy, m_ceab});
    end
    rst = 1'b0;
    in_valid = 1'b0;
    mon_en = 1'b1;
    step();
    vectors++;
    if (m_busy !== 1'b0 || m_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b want 0 0", m_busy, m_rdy);
    end
  endtask

  task automatic test_basic();
    int t0, at;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd3; in_valid = 1'b1;
    src_q.push_back(2); src_q.push_back(3); src_q.push_back(4);
    step();
    start = 1'b0;
    wait_done(20, at);
    vectors++;
    if (at !== t0 + 6) begin
      miscompares++;
      $display("FAIL basic_done_cyc: got %0d want %0d", at - t0, 6);
    end
    vectors++;
    if (p_model !== 9) begin
      miscompares++;
      $display("FAIL basic_p: got %0d want 9", p_model);
    end
    vectors++;
    if (first_acc_cyc !== t0 + 1 || acc_n !== 3) begin
      miscompares++;
      $display("FAIL basic_accepts: got first=%0d n=%0d want first=1 n=3", first_acc_cyc - t0, acc_n);
    end
    vectors++;
    if (m_busy !== 1'b1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL basic_at_done: got busy=%b pending=%0d want 1 0", m_busy, exp_q.size());
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_fall: got busy=%b done=%b want 0 0", m_busy, m_done);
    end
  endtask

  task automatic test_stall();
    int t0, at;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd3; in_valid = 1'b1;
    src_q.push_back(2); src_q.push_back(3); src_q.push_back(4);
    step(); start = 1'b0;
    step(); in_valid = 1'b0;
    step(); in_valid = 1'b1;
    step();
    vectors++;
    if (m_cep !== 1'b0 || m_op !== 8'h00) begin
      miscompares++;
      $display("FAIL stall_bubble: got ce_p=%b opmode=%h want 0 00", m_cep, m_op);
    end
    wait_done(20, at);
    vectors++;
    if (at !== t0 + 7 || p_model !== 9) begin
      miscompares++;
      $display("FAIL stall_done: got cyc=%0d P=%0d want cyc=7 P=9", at - t0, p_model);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_len0();
    int t0, at;
    bit seen_rdy;
    exp_t e;
    t0 = cyc; acc_n = 0; seen_rdy = 1'b0; at = -1;
    start = 1'b1; len = 8'd0; in_valid = 1'b1;
    e = '{t0 + 1 + OPM_LAT, 8'h00, 0};
    exp_q.push_back(e);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) start = 1'b0;
      if (m_rdy !== 1'b0) seen_rdy = 1'b1;
      if (m_done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    vectors++;
    if (at !== t0 + 4 || seen_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_done: got cyc=%0d rdy_seen=%b want cyc=4 rdy_seen=0", at - t0, seen_rdy);
    end
    vectors++;
    if (p_model !== 0 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL len0_clear: got P=%0d pending=%0d want 0 0", p_model, exp_q.size());
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_sub();
    int t0, at;
    sel = 1'b1;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd2; in_valid = 1'b1;
    src_q.push_back(5); src_q.push_back(3);
    step(); start = 1'b0;
    wait_done(20, at);
    vectors++;
    if (at !== t0 + 5 || p_model !== -8) begin
      miscompares++;
      $display("FAIL sub_result: got cyc=%0d P=%0d want cyc=5 P=-8", at - t0, p_model);
    end
    step();
    in_valid = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_reset_midjob();
    int t0, t1, at;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd4; in_valid = 1'b1;
    src_q.push_back(9); src_q.push_back(9); src_q.push_back(9); src_q.push_back(9);
    step(); start = 1'b0;
    step();
    step(); rst = 1'b1;
    step();
    vectors++;
    if ({m_cep, m_busy, m_done, m_rdy} !== 4'b0 || m_op !== 8'h00) begin
      miscompares++;
      $display("FAIL midjob_reset: got flags=%b opmode=%h want 0000 00", {m_cep, m_busy, m_done, m_rdy}, m_op);
    end
    exp_q.delete();
    src_q.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    t1 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd2; in_valid = 1'b1;
    src_q.push_back(1); src_q.push_back(1);
    step(); start = 1'b0;
    wait_done(20, at);
    vectors++;
    if (at !== t1 + 5 || p_model !== 2) begin
      miscompares++;
      $display("FAIL after_reset_job: got cyc=%0d P=%0d want cyc=5 P=2", at - t1, p_model);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_ignore_start();
    int t0, at;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd3; in_valid = 1'b1;
    src_q.push_back(1); src_q.push_back(2); src_q.push_back(3);
    step(); start = 1'b0;
    step(); start = 1'b1; len = 8'd7;
    step();
    step();
    step(); start = 1'b0;
    wait_done(20, at);
    vectors++;
    if (at !== t0 + 6 || p_model !== 6 || acc_n !== 3) begin
      miscompares++;
      $display("FAIL ignore_start: got cyc=%0d P=%0d n=%0d want cyc=6 P=6 n=3", at - t0, p_model, acc_n);
    end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (m_cep !== 1'b0 || m_busy !== 1'b0 || p_model !== 6) begin
        miscompares++;
        $display("FAIL hold_idle %0d: got ce_p=%b busy=%b P=%0d want 0 0 6", i, m_cep, m_busy, p_model);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, at;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd1; in_valid = 1'b1;
    src_q.push_back(7);
    step(); start = 1'b0;
    wait_done(20, at);
    vectors++;
    if (at !== t0 + 4 || p_model !== 7) begin
      miscompares++;
      $display("FAIL b2b_first: got cyc=%0d P=%0d want cyc=4 P=7", at - t0, p_model);
    end
    step();
    vectors++;
    if (m_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy=%b want 0", m_busy);
    end
    t1 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd1;
    src_q.push_back(4);
    step(); start = 1'b0;
    wait_done(20, at);
    vectors++;
    if (at !== t1 + 4 || p_model !== 4) begin
      miscompares++;
      $display("FAIL b2b_second: got cyc=%0d P=%0d want cyc=4 P=4", at - t1, p_model);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_max_len();
    int t0, at;
    t0 = cyc; acc_n = 0;
    start = 1'b1; len = 8'd255; in_valid = 1'b1;
    for (int i = 0; i < 255; i++) src_q.push_back(1);
    step(); start = 1'b0;
    wait_done(300, at);
    vectors++;
    if (at !== t0 + 258 || p_model !== 255 || acc_n !== 255) begin
      miscompares++;
      $display("FAIL max_len: got cyc=%0d P=%0d n=%0d want cyc=258 P=255 n=255", at - t0, p_model, acc_n);
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_sub();
    test_reset_midjob();
    test_ignore_start();
    test_back_to_back();
    test_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
